// File: rtl/router_fsm_pkg.sv
// rtl/router_fsm_pkg.sv - shared router constants: FSM state encoding and address codes.
package router_fsm_pkg;

  typedef enum logic [2:0] {
    S_DA  = 3'd0,
    S_LFD = 3'd1,
    S_LD  = 3'd2,
    S_FFS = 3'd3,
    S_LAF = 3'd4,
    S_LP  = 3'd5,
    S_CPE = 3'd6,
    S_WTE = 3'd7
  } state_t;

  localparam logic [1:0] ADDR0        = 2'd0;
  localparam logic [1:0] ADDR1        = 2'd1;
  localparam logic [1:0] ADDR2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - 1x3 router controller: address decode, load sequencing, full stall, drain wait.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic [1:0] data_in,
  output logic       busy,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       lfd_state
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       w_addr_ok;
  logic       w_soft_rst;
  logic       w_empty_in;
  logic       w_empty_lat;

  assign w_addr_ok = pkt_valid && (data_in != ADDR_INVALID);

  always_comb begin
    w_soft_rst  = 1'b0;
    w_empty_lat = 1'b0;
    case (r_addr)
      ADDR0:   begin w_soft_rst = soft_reset_0; w_empty_lat = fifo_empty_0; end
      ADDR1:   begin w_soft_rst = soft_reset_1; w_empty_lat = fifo_empty_1; end
      ADDR2:   begin w_soft_rst = soft_reset_2; w_empty_lat = fifo_empty_2; end
      default: begin w_soft_rst = 1'b0;         w_empty_lat = 1'b0;         end
    endcase
  end

  // DA picks the empty flag from the live header; WTE uses the latched address.
  always_comb begin
    w_empty_in = 1'b0;
    case (data_in)
      ADDR0:   w_empty_in = fifo_empty_0;
      ADDR1:   w_empty_in = fifo_empty_1;
      ADDR2:   w_empty_in = fifo_empty_2;
      default: w_empty_in = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (w_soft_rst) begin
      w_next = S_DA;
    end else begin
      case (r_state)
        S_DA:  if (w_addr_ok) w_next = w_empty_in ? S_LFD : S_WTE;
        S_LFD: w_next = S_LD;
        S_LD:  if (fifo_full) w_next = S_FFS;
               else if (!pkt_valid) w_next = S_LP;
        S_FFS: if (!fifo_full) w_next = S_LAF;
        S_LAF: if (parity_done) w_next = S_DA;
               else w_next = low_pkt_valid ? S_LP : S_LD;
        S_LP:  w_next = S_CPE;
        S_CPE: w_next = fifo_full ? S_FFS : S_DA;
        S_WTE: if (w_empty_lat) w_next = S_LFD;
        default: w_next = S_DA;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they track the state with no lag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_DA;
      r_addr        <= ADDR0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DA && w_addr_ok)
        r_addr <= data_in;
      detect_add    <= (w_next == S_DA);
      lfd_state     <= (w_next == S_LFD);
      ld_state      <= (w_next == S_LD);
      laf_state     <= (w_next == S_LAF);
      full_state    <= (w_next == S_FFS);
      rst_int_reg   <= (w_next == S_CPE);
      write_enb_reg <= (w_next == S_LD) || (w_next == S_LAF) || (w_next == S_LP);
      busy          <= !((w_next == S_DA) || (w_next == S_LD));
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed-vector bench for router_fsm with hand-computed output patterns.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, parity_done, fifo_full, low_pkt_valid;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [1:0] data_in;
  logic       busy, detect_add, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, lfd_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Packed as {busy, detect_add, ld, laf, full, write_enb, rst_int, lfd}
  localparam logic [7:0] E_DA  = 8'b0100_0000;
  localparam logic [7:0] E_LFD = 8'b1000_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0100;
  localparam logic [7:0] E_LAF = 8'b1001_0100;
  localparam logic [7:0] E_FFS = 8'b1000_1000;
  localparam logic [7:0] E_LP  = 8'b1000_0100;
  localparam logic [7:0] E_CPE = 8'b1000_0010;
  localparam logic [7:0] E_WTE = 8'b1000_0000;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .parity_done(parity_done),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .data_in(data_in), .busy(busy), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .lfd_state(lfd_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {busy, detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state};
  endfunction

  task automatic tick(input string tag, input logic [7:0] exp);
    @(posedge clock);
    #1;
    check(tag, outs(), exp);
  endtask

  task automatic start_pkt(input logic [1:0] a);
    pkt_valid = 1'b1;
    data_in   = a;
    tick("hdr_lfd", E_LFD);
    tick("hdr_ld", E_LD);
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 0; parity_done = 0; fifo_full = 0; low_pkt_valid = 0;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1; data_in = 2'd0;
    tick("reset", E_DA);
    reset = 1'b0;
    tick("idle", E_DA);

    // Normal packet to FIFO 1
    start_pkt(2'd1);
    tick("ld_hold", E_LD);
    pkt_valid = 0;
    tick("norm_lp", E_LP);
    tick("norm_cpe", E_CPE);
    tick("norm_da", E_DA);

    // Full stall then pkt_valid already low
    start_pkt(2'd1);
    fifo_full = 1;
    tick("f1_ffs", E_FFS);
    tick("f1_ffs_hold", E_FFS);
    fifo_full = 0; pkt_valid = 0; low_pkt_valid = 1;
    tick("f1_laf", E_LAF);
    tick("f1_lp", E_LP);
    low_pkt_valid = 0;
    tick("f1_cpe", E_CPE);
    tick("f1_da", E_DA);

    // Full stall then payload continues
    start_pkt(2'd0);
    fifo_full = 1;
    tick("f2_ffs", E_FFS);
    fifo_full = 0;
    tick("f2_laf", E_LAF);
    tick("f2_ld", E_LD);
    pkt_valid = 0;
    tick("f2_lp", E_LP);
    tick("f2_cpe", E_CPE);
    tick("f2_da", E_DA);

    // CPE with FIFO full, then LAF exits on parity_done
    start_pkt(2'd1);
    pkt_valid = 0;
    tick("p_lp", E_LP);
    fifo_full = 1;
    tick("p_cpe", E_CPE);
    tick("p_ffs", E_FFS);
    fifo_full = 0; parity_done = 1; low_pkt_valid = 1;
    tick("p_laf", E_LAF);
    tick("p_da", E_DA);
    parity_done = 0; low_pkt_valid = 0;

    // Busy destination FIFO 2; WTE must ignore live header and FIFO 1 flag
    fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'd2;
    tick("w_wte1", E_WTE);
    pkt_valid = 0; data_in = 2'd1; fifo_empty_1 = 1;
    tick("w_wte2", E_WTE);
    tick("w_wte3", E_WTE);
    fifo_empty_2 = 1;
    tick("w_lfd", E_LFD);
    tick("w_ld", E_LD);
    tick("w_lp", E_LP);
    tick("w_cpe", E_CPE);
    tick("w_da", E_DA);

    // Invalid address stays in DA
    pkt_valid = 1; data_in = 2'd3;
    tick("inv_da1", E_DA);
    tick("inv_da2", E_DA);
    pkt_valid = 0;

    // Soft reset: only the latched address's line matters
    start_pkt(2'd1);
    soft_reset_0 = 1;
    tick("sr0_ignored", E_LD);
    soft_reset_0 = 0; soft_reset_1 = 1;
    tick("sr1_da", E_DA);
    soft_reset_1 = 0; pkt_valid = 0;
    tick("sr_idle", E_DA);

    // Synchronous reset mid-packet
    start_pkt(2'd2);
    reset = 1;
    tick("rst_mid", E_DA);
    reset = 0; pkt_valid = 0;
    tick("rst_idle", E_DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
